// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute/update control sequencer for a simple PC datapath.
//
// Purpose:
//   Walks IDLE -> FETCH -> EXEC -> UPDATE -> FETCH ... and stops in HALT when a
//   halt has been requested. Every instruction that has entered FETCH runs to
//   completion, including its single-cycle PC update, unless reset aborts it.
//   All outputs are registered: each output flop is loaded from a value derived
//   from the next state, so outputs line up with the state they belong to.
//
// Optional feature (macro SEQ_TIMEOUT_EN):
//   When defined, FETCH gives up after TIMEOUT cycles without imem_ack and the
//   sequencer enters the terminal ERR state with err set. When undefined, there
//   is no counter, FETCH waits forever and err is tied to 0.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start              leave IDLE and begin sequencing
//   halt_req           stop after the current instruction
//   imem_ack/imem_data instruction memory response (used only in FETCH)
//   exec_done          execute finished (used only in EXEC), with br_taken/br_offset
//   imem_req           fetch request, high in every FETCH cycle
//   en_cnt/en_offset   PC increment / PC add-offset enables (UPDATE only, exclusive)
//   pc_offset          branch offset to the PC (UPDATE only, else 0)
//   ir, ir_valid       instruction register and its EXEC-only valid flag
//   state, err         current state encoding, fetch timeout flag
module pc_sequencer #(
    parameter int unsigned SZB     = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           halt_req,
    input  logic           imem_ack,
    input  logic [SZB-1:0] imem_data,
    input  logic           exec_done,
    input  logic           br_taken,
    input  logic [SZB-1:0] br_offset,
    output logic           imem_req,
    output logic           en_cnt,
    output logic           en_offset,
    output logic [SZB-1:0] pc_offset,
    output logic [SZB-1:0] ir,
    output logic           ir_valid,
    output logic [2:0]     state,
    output logic           err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALT   = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic           imem_req_q, imem_req_d;
    logic           en_cnt_q, en_cnt_d;
    logic           en_offset_q, en_offset_d;
    logic [SZB-1:0] pc_offset_q, pc_offset_d;
    logic [SZB-1:0] ir_q, ir_d;
    logic           ir_valid_q, ir_valid_d;
    logic           halt_pend_q, halt_pend_d;
    logic           timeout_c;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counter holds the number of ack-less FETCH cycles already spent; the
    // TIMEOUT-th such cycle redirects to ERR.
    always_comb begin
        timeout_c = (state_q == S_FETCH) && !imem_ack
                    && (32'(cnt_q) == TIMEOUT - 32'd1);
        cnt_d     = cnt_q;
        if ((state_q == S_FETCH) && !imem_ack && !timeout_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            cnt_d = '0;
        end
        err_d = err_q | (state_d == S_ERR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign timeout_c      = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        halt_pend_d = halt_pend_q;
        en_cnt_d    = 1'b0;
        en_offset_d = 1'b0;
        pc_offset_d = '0;

        case (state_q)
            S_IDLE: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                halt_pend_d = halt_pend_q | halt_req;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end else if (timeout_c) begin
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                halt_pend_d = halt_pend_q | halt_req;
                // The UPDATE-cycle enables capture the branch outcome here.
                if (exec_done) begin
                    state_d     = S_UPDATE;
                    en_offset_d = br_taken;
                    en_cnt_d    = !br_taken;
                    pc_offset_d = br_taken ? br_offset : '0;
                end
            end
            S_UPDATE: begin
                halt_pend_d = halt_pend_q | halt_req;
                state_d     = (halt_pend_q || halt_req) ? S_HALT : S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        imem_req_d = (state_d == S_FETCH);
        ir_valid_d = (state_d == S_EXEC);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            imem_req_q  <= 1'b0;
            en_cnt_q    <= 1'b0;
            en_offset_q <= 1'b0;
            pc_offset_q <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            en_cnt_q    <= en_cnt_d;
            en_offset_q <= en_offset_d;
            pc_offset_q <= pc_offset_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign state     = state_q;
    assign imem_req  = imem_req_q;
    assign en_cnt    = en_cnt_q;
    assign en_offset = en_offset_q;
    assign pc_offset = pc_offset_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed stimulus, PC-update events checked by a
// scoreboard monitor, plus direct state/output checks from the stimulus thread.
module tb_pc_sequencer;

    localparam int unsigned SZB = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic           start, halt_req, imem_ack, exec_done, br_taken;
    logic [SZB-1:0] imem_data, br_offset;
    logic           imem_req, en_cnt, en_offset, ir_valid, err;
    logic [SZB-1:0] pc_offset, ir;
    logic [2:0]     state;

    typedef struct packed {
        logic           cnt;
        logic           off;
        logic [SZB-1:0] pcoff;
        logic [SZB-1:0] ir;
    } upd_t;

    upd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer #(.SZB(SZB), .TIMEOUT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .halt_req  (halt_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .exec_done (exec_done),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .imem_req  (imem_req),
        .en_cnt    (en_cnt),
        .en_offset (en_offset),
        .pc_offset (pc_offset),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .state     (state),
        .err       (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 1 time unit after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_inputs();
        start = 0; halt_req = 0; imem_ack = 0; exec_done = 0; br_taken = 0;
        imem_data = '0; br_offset = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // Scoreboard monitor: every PC enable pulse must match the next expected update.
    always @(negedge clock) begin
        if (!reset && (en_cnt || en_offset)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: en_cnt=%0b en_offset=%0b pc_offset=0x%0h expected none",
                         en_cnt, en_offset, pc_offset);
            end else begin
                upd_t e;
                upd_t a;
                e = exp_q.pop_front();
                a = '{cnt: en_cnt, off: en_offset, pcoff: pc_offset, ir: ir};
                if (a !== e) begin
                    errors++;
                    $display("FAIL update: got cnt=%0b off=%0b pc_offset=0x%0h ir=0x%0h expected cnt=%0b off=%0b pc_offset=0x%0h ir=0x%0h",
                             a.cnt, a.off, a.pcoff, a.ir, e.cnt, e.off, e.pcoff, e.ir);
                end
            end
        end
    end

    initial begin
        do_reset();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ir", 32'(ir), 32'h0);
        chk("reset_outs", 32'({imem_req, ir_valid, en_cnt, en_offset, err}), 32'd0);
        chk("reset_pc_offset", 32'(pc_offset), 32'h0);

        // Sequential instruction: fetch 0x1234, not taken.
        start = 1; step(); start = 0;
        chk("fetch_state", 32'(state), 32'd1);
        chk("fetch_req", 32'(imem_req), 32'd1);
        imem_ack = 1; imem_data = 16'h1234; step(); imem_ack = 0; imem_data = 16'h0;
        chk("exec_state", 32'(state), 32'd2);
        chk("exec_ir", 32'(ir), 32'h1234);
        chk("exec_flags", 32'({ir_valid, imem_req}), 32'b10);
        exp_q.push_back('{cnt: 1'b1, off: 1'b0, pcoff: 16'h0, ir: 16'h1234});
        exec_done = 1; br_taken = 0; step(); exec_done = 0;
        chk("update_state", 32'(state), 32'd3);
        chk("update_ir_valid", 32'(ir_valid), 32'd0);
        step();
        chk("loop_fetch", 32'(state), 32'd1);
        chk("loop_enables_clear", 32'({en_cnt, en_offset}), 32'd0);

        // exec_done ignored in FETCH.
        exec_done = 1; step(); exec_done = 0;
        chk("fetch_ignores_done", 32'(state), 32'd1);

        // Taken branch with offset 0xFFFC; stray ack ignored in EXEC.
        imem_ack = 1; imem_data = 16'hABCD; step();
        imem_data = 16'h9999; step(); imem_ack = 0;
        chk("exec_ignores_ack", 32'(ir), 32'hABCD);
        chk("exec_hold", 32'(state), 32'd2);
        exp_q.push_back('{cnt: 1'b0, off: 1'b1, pcoff: 16'hFFFC, ir: 16'hABCD});
        exec_done = 1; br_taken = 1; br_offset = 16'hFFFC; step();
        exec_done = 0; br_taken = 0; br_offset = 16'h0;
        chk("branch_update", 32'(state), 32'd3);
        step();
        chk("branch_back_fetch", 32'(state), 32'd1);
        chk("pc_offset_cleared", 32'(pc_offset), 32'h0);

        // Halt pulsed in EXEC: instruction still completes, then terminal HALT.
        imem_ack = 1; imem_data = 16'h5555; step(); imem_ack = 0;
        halt_req = 1; step(); halt_req = 0;
        chk("halt_pending_exec", 32'(state), 32'd2);
        exp_q.push_back('{cnt: 1'b1, off: 1'b0, pcoff: 16'h0, ir: 16'h5555});
        exec_done = 1; step(); exec_done = 0;
        chk("halt_update", 32'(state), 32'd3);
        step();
        chk("halt_state", 32'(state), 32'd4);
        start = 1; imem_ack = 1; step(3); start = 0; imem_ack = 0;
        chk("halt_terminal", 32'(state), 32'd4);
        chk("halt_no_req", 32'(imem_req), 32'd0);
        chk("halt_ir_kept", 32'(ir), 32'h5555);

        // Fetch timeout (or endless wait without the feature).
        do_reset();
        start = 1; step(); start = 0;
`ifdef SEQ_TIMEOUT_EN
        step(14);
        chk("timeout_still_fetch", 32'(state), 32'd1);
        step();
        chk("timeout_err_state", 32'(state), 32'd5);
        chk("timeout_err_flag", 32'(err), 32'd1);
        chk("timeout_no_req", 32'(imem_req), 32'd0);
        imem_ack = 1; start = 1; step(3); imem_ack = 0; start = 0;
        chk("err_terminal", 32'({state, err}), 32'({3'd5, 1'b1}));
`else
        step(100);
        chk("no_timeout_state", 32'(state), 32'd1);
        chk("no_timeout_err", 32'(err), 32'd0);
        chk("no_timeout_req", 32'(imem_req), 32'd1);
`endif

        // Reset asserted mid-clock during UPDATE: enable drops at once, no pulse after.
        do_reset();
        start = 1; step(); start = 0;
        imem_ack = 1; imem_data = 16'h0F0F; step(); imem_ack = 0;
        exec_done = 1; step(); exec_done = 0;
        chk("pre_reset_update", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_enables", 32'({en_cnt, en_offset}), 32'd0);
        chk("async_reset_ir", 32'(ir), 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("post_reset_enables", 32'({en_cnt, en_offset, imem_req}), 32'd0);

        // halt_req wins over start in IDLE.
        halt_req = 1; start = 1; step(); halt_req = 0; start = 0;
        chk("idle_halt_priority", 32'(state), 32'd4);
        chk("idle_halt_no_req", 32'(imem_req), 32'd0);

        step(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter SZB, default 16, instruction/PC word width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, max FETCH cycles without imem_ack (used only when SEQ_TIMEOUT_EN defined).
REQ-003 SHALL have port clock  in  1  system clock, rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  leave IDLE and begin sequencing.
REQ-006 SHALL have port halt_req  in  1  request stop after current instruction.
REQ-007 SHALL have port imem_ack  in  1  instruction memory data valid.
REQ-008 SHALL have port imem_data  in  SZB  fetched instruction word.
REQ-009 SHALL have port exec_done  in  1  execute stage finished current instruction.
REQ-010 SHALL have port br_taken  in  1  branch taken, sampled with exec_done.
REQ-011 SHALL have port br_offset  in  SZB  branch offset, sampled with exec_done.
REQ-012 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-013 SHALL have ports en_cnt, en_offset  out  1 each  PC increment / PC offset enables.
REQ-014 SHALL have port pc_offset  out  SZB  offset driven to PC.
REQ-015 SHALL have ports ir  out  SZB  instruction register; ir_valid  out  1  ir holds live instruction.
REQ-016 SHALL have ports state  out  3  current FSM encoding; err  out  1  fetch timeout flag.

Function
REQ-017 SHALL implement states IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALT=4, ERR=5; all outputs registered.
REQ-018 IDLE: start=1 -> FETCH next cycle; halt_req=1 (priority over start) -> HALT.
REQ-019 FETCH: imem_req=1 every cycle in state; on imem_ack=1 SHALL latch imem_data into ir, -> EXEC; else remain.
REQ-020 EXEC: ir_valid=1, imem_req=0; on exec_done=1 SHALL latch br_taken and br_offset, -> UPDATE.
REQ-021 UPDATE: exactly one cycle; taken -> en_offset=1, pc_offset=latched offset, en_cnt=0; not taken -> en_cnt=1, en_offset=0, pc_offset=0.
REQ-022 en_cnt and en_offset SHALL never be 1 simultaneously and SHALL be 0 outside UPDATE; pc_offset SHALL be 0 outside UPDATE.
REQ-023 UPDATE -> HALT if halt pending, else -> FETCH; fetch-to-fetch minimum loop = 3 cycles (FETCH with ack, EXEC with exec_done, UPDATE).
REQ-024 halt_req SHALL be captured as sticky pending flag in FETCH/EXEC/UPDATE; acted on only at UPDATE exit; current instruction always completes and PC always updated.
REQ-025 HALT and ERR SHALL be terminal: all enables/requests 0; exit only via reset; start ignored.
REQ-026 ir SHALL hold last fetched value until next ack; ir_valid=0 in all states except EXEC.
REQ-027 exec_done and imem_ack SHALL be ignored in states other than EXEC and FETCH respectively.

Reset
REQ-028 reset=1 SHALL asynchronously force state=IDLE, ir=0, ir_valid=0, imem_req=0, en_cnt=0, en_offset=0, pc_offset=0, err=0, halt pending=0, timeout counter=0.
REQ-029 reset mid-FETCH/EXEC/UPDATE SHALL abort the instruction with no PC enable pulse after reset assertion.

Configuration
REQ-030 Macro SEQ_TIMEOUT_EN defined: counter clears on FETCH entry, increments each FETCH cycle without imem_ack; when it reaches TIMEOUT without ack, next state=ERR, err=1 (sticky until reset), imem_req=0.
REQ-031 SEQ_TIMEOUT_EN undefined: no counter, err tied 0, FETCH waits indefinitely, ERR unreachable.

Verification
REQ-032 reset, start=1 one cycle, ack 1 cycle after request with imem_data=0x1234, exec_done next cycle br_taken=0 -> ir=0x1234, one-cycle en_cnt=1, back to FETCH.
REQ-033 exec_done with br_taken=1, br_offset=0xFFFC -> one cycle en_offset=1, pc_offset=0xFFFC, en_cnt=0.
REQ-034 halt_req pulsed during EXEC -> UPDATE still pulses en_cnt, then state=4, imem_req stays 0 despite start=1.
REQ-035 SEQ_TIMEOUT_EN, TIMEOUT=15, imem_ack held 0 -> ERR entered after 15 FETCH cycles, err=1, imem_req=0; without macro, state stays 1 after 100 cycles.
REQ-036 reset asserted in UPDATE cycle mid-clock -> en_cnt/en_offset drop immediately, state=0, no PC enable on following edge.
